// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   pc_state_t : sequencer state (BOOT, RUN, HALTED)
//   PC_STEP    : sequential fetch increment in bytes
//   ALIGN_MASK : low PC bits that must be zero for a legal target
package pc_seq_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_t;
    localparam int unsigned PC_STEP    = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;
endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the core and the PC sequencer.
//   master : core side, drives redirect/stall/halt requests, reads PC state
//   slave  : sequencer side
interface pc_sequencer_if #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 64
);
    logic                 Stall;
    logic                 BranchTaken;
    logic [DWIDTH-1:0]    BranchTarget;
    logic                 Trap;
    logic                 MRet;
    logic                 Halt;
    logic                 Resume;
    logic [DWIDTH-1:0]    PC;
    logic [DWIDTH-1:0]    PCPlus4;
    logic [DWIDTH-1:0]    Epc;
    logic                 Valid;
    logic                 Misaligned;
    logic [CNT_WIDTH-1:0] RetireCount;

    modport master (
        output Stall, BranchTaken, BranchTarget, Trap, MRet, Halt, Resume,
        input  PC, PCPlus4, Epc, Valid, Misaligned, RetireCount
    );
    modport slave (
        input  Stall, BranchTaken, BranchTarget, Trap, MRet, Halt, Resume,
        output PC, PCPlus4, Epc, Valid, Misaligned, RetireCount
    );
endinterface

// File: rtl/pc_sequencer_wrap_counter.sv
// Free-running up counter with synchronous clear and enable; wraps
// from all-ones back to zero.
//   clk   : clock, rising edge
//   clr   : synchronous clear, active-high, dominates en
//   en    : increment this cycle
//   count : current count (registered)
module wrap_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer at the head of the fetch path. Holds the
// architectural PC and picks the next PC from trap, stall, trap-return,
// branch and sequential sources; adds a post-reset boot delay,
// halt/resume, misaligned-target trapping and a retired-instruction count.
//   Clk : clock, rising edge
//   Rst : synchronous reset, active-high
//   bus : request inputs and PC/Epc/Valid/Misaligned/RetireCount outputs
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DWIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              BOOT_DELAY   = 2,
    parameter int              CNT_WIDTH    = 64
) (
    input  logic    Clk,
    input  logic    Rst,
    pc_sequencer_if.slave bus
);
    // Boot counter runs 0 .. BOOT_DELAY-1; the last value triggers RUN.
    localparam int            BW        = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
    localparam pc_state_t     RST_STATE = (BOOT_DELAY == 0) ? RUN : BOOT;

    pc_state_t         state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] epc_q, epc_d;
    logic [BW-1:0]     boot_cnt_q, boot_cnt_d;

    logic [DWIDTH-1:0] pc_plus4;
    logic              misaligned;
    logic              take_trap;
    logic              retire;

    assign pc_plus4   = pc_q + DWIDTH'(PC_STEP);
    assign misaligned = (state_q == RUN) && bus.BranchTaken &&
                        ((bus.BranchTarget[1:0] & ALIGN_MASK) != 2'b00);
    // Trap outranks stall, so a stalled cycle can still be redirected.
    assign take_trap  = (state_q == RUN) && (bus.Trap || misaligned);
    assign retire     = (state_q == RUN) && !take_trap && !bus.Stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) state_d = RUN;
                else                         boot_cnt_d = boot_cnt_q + 1'b1;
            end
            RUN: begin
                if (take_trap) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (!bus.Stall) begin
                    if (bus.MRet)             pc_d = epc_q;
                    else if (bus.BranchTaken) pc_d = bus.BranchTarget;
                    else                      pc_d = pc_plus4;
                    // Halt lets this cycle's update land, then freezes.
                    if (bus.Halt) state_d = HALTED;
                end
            end
            HALTED: begin
                if (bus.Resume) state_d = RUN;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= RST_STATE;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    wrap_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
        .clk   (Clk),
        .clr   (Rst),
        .en    (retire),
        .count (bus.RetireCount)
    );

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.Epc        = epc_q;
    assign bus.Valid      = (state_q == RUN);
    assign bus.Misaligned = misaligned;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    localparam int BOOT_DELAY = 2;
    localparam int CW         = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    pc_sequencer_if #(.DWIDTH(32), .CNT_WIDTH(CW)) bus ();

    pc_sequencer #(
        .DWIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
        .BOOT_DELAY(BOOT_DELAY), .CNT_WIDTH(CW)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, stall, bt;
        logic [31:0] tgt;
        logic        trap, mret, halt, resume;
        logic [31:0] pc, epc;
        logic        valid;
        logic [3:0]  cnt;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc, epc;
        logic        valid;
        logic [3:0]  cnt;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t v(logic r, logic s, logic b, logic [31:0] t, logic tr, logic m,
                               logic h, logic rs, logic [31:0] p, logic [31:0] e, logic vl,
                               logic [3:0] c, logic ms);
        vec_t x;
        x.rst = r; x.stall = s; x.bt = b; x.tgt = t; x.trap = tr; x.mret = m;
        x.halt = h; x.resume = rs; x.pc = p; x.epc = e; x.valid = vl; x.cnt = c; x.mis = ms;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = '0;
        bus.Trap = 0; bus.MRet = 0; bus.Halt = 0; bus.Resume = 0;
    endtask

    initial begin
        logic [31:0] prev_pc;
        exp_t        e;
        int          n;

        // rst stall bt tgt trap mret halt resume | pc epc valid cnt | mis
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h0,32'h0,0,0,0));                  // BOOT
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h0,32'h0,1,0,0));                  // -> RUN
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h4,32'h0,1,1,0));
        vecs.push_back(v(0,0,1,32'hA5A5A5A4,0,0,0,0, 32'hA5A5A5A4,32'h0,1,2,0));
        vecs.push_back(v(0,0,1,32'h5A5A5A5A,0,0,0,0, 32'h100,32'hA5A5A5A4,1,2,1));  // misaligned
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h104,32'hA5A5A5A4,1,3,0));
        vecs.push_back(v(0,0,1,32'h20,0,0,0,0, 32'h20,32'hA5A5A5A4,1,4,0));
        vecs.push_back(v(0,0,0,32'h0,1,0,0,0, 32'h100,32'h20,1,4,0));               // trap
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h104,32'h20,1,5,0));
        vecs.push_back(v(0,0,0,32'h0,0,1,0,0, 32'h20,32'h20,1,6,0));                // mret
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,1,1,32'h80,0,0,0,0, 32'h20,32'h20,1,6,0));           // stall+bt
        vecs.push_back(v(0,1,0,32'h0,1,0,0,0, 32'h100,32'h20,1,6,0));               // stall+trap
        vecs.push_back(v(0,1,0,32'h0,0,1,1,0, 32'h100,32'h20,1,6,0));               // stall beats halt/mret
        vecs.push_back(v(0,0,1,32'h40,0,0,0,0, 32'h40,32'h20,1,7,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,1,0, 32'h44,32'h20,0,8,0));                // halt
        vecs.push_back(v(0,0,1,32'h80,0,0,0,0, 32'h44,32'h20,0,8,0));
        vecs.push_back(v(0,0,0,32'h0,1,0,0,0, 32'h44,32'h20,0,8,0));
        vecs.push_back(v(0,0,1,32'h81,0,0,0,0, 32'h44,32'h20,0,8,0));               // no mis in HALTED
        vecs.push_back(v(0,0,0,32'h0,0,1,0,0, 32'h44,32'h20,0,8,0));
        vecs.push_back(v(0,1,0,32'h0,0,0,1,0, 32'h44,32'h20,0,8,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,0,1, 32'h44,32'h20,1,8,0));                // resume
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h48,32'h20,1,9,0));
        vecs.push_back(v(0,0,0,32'h0,1,0,1,0, 32'h100,32'h48,1,9,0));               // trap beats halt
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h104,32'h48,1,10,0));
        vecs.push_back(v(0,0,1,32'h200,0,0,1,0, 32'h200,32'h48,0,11,0));            // halt + branch
        vecs.push_back(v(0,0,0,32'h0,0,0,0,1, 32'h200,32'h48,1,11,0));
        vecs.push_back(v(0,0,1,32'hFFFFFFFC,0,0,0,0, 32'hFFFFFFFC,32'h48,1,12,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h0,32'h48,1,13,0));                // PC wrap
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h4,32'h48,1,14,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h8,32'h48,1,15,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'hC,32'h48,1,0,0));                 // count wrap
        vecs.push_back(v(0,0,0,32'h0,0,1,0,0, 32'h48,32'h48,1,1,0));
        vecs.push_back(v(0,1,0,32'h0,0,0,1,0, 32'h48,32'h48,1,1,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,1,0, 32'h4C,32'h48,0,2,0));                // halt
        vecs.push_back(v(1,0,0,32'h0,1,0,0,1, 32'h0,32'h0,0,0,0));                  // reset in HALTED
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h0,32'h0,0,0,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h0,32'h0,1,0,0));
        vecs.push_back(v(0,0,0,32'h0,0,0,0,0, 32'h4,32'h0,1,1,0));

        drive_idle();
        Rst = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_epc", bus.Epc, 32'h0);
        chk("rst_valid", {31'b0, bus.Valid}, 32'h0);
        chk("rst_cnt", {28'b0, bus.RetireCount}, 32'h0);
        Rst = 0;
        prev_pc = 32'h0;

        foreach (vecs[i]) begin
            Rst = vecs[i].rst;
            bus.Stall = vecs[i].stall; bus.BranchTaken = vecs[i].bt;
            bus.BranchTarget = vecs[i].tgt; bus.Trap = vecs[i].trap;
            bus.MRet = vecs[i].mret; bus.Halt = vecs[i].halt; bus.Resume = vecs[i].resume;
            e.pc = vecs[i].pc; e.epc = vecs[i].epc; e.valid = vecs[i].valid; e.cnt = vecs[i].cnt;
            sb.push_back(e);
            @(negedge Clk);
            chk($sformatf("v%0d_mis", i), {31'b0, bus.Misaligned}, {31'b0, vecs[i].mis});
            chk($sformatf("v%0d_pc4", i), bus.PCPlus4, prev_pc + 32'd4);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_pc", i), bus.PC, e.pc);
            chk($sformatf("v%0d_epc", i), bus.Epc, e.epc);
            chk($sformatf("v%0d_valid", i), {31'b0, bus.Valid}, {31'b0, e.valid});
            chk($sformatf("v%0d_cnt", i), {28'b0, bus.RetireCount}, {28'b0, e.cnt});
            prev_pc = e.pc;
        end
        Rst = 0;
        drive_idle();

        // Boot latency: reset mid-trap, then count edges until Valid rises.
        bus.Trap = 1;
        Rst = 1;
        @(posedge Clk);
        #1;
        Rst = 0;
        bus.Trap = 0;
        chk("boot_pc_after_rst", bus.PC, 32'h0);
        n = 0;
        while (!bus.Valid && n < 10) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("boot_latency", n, BOOT_DELAY);
        chk("boot_first_pc", bus.PC, 32'h0);
        @(posedge Clk);
        #1;
        chk("boot_second_pc", bus.PC, 32'h4);
        chk("boot_second_cnt", {28'b0, bus.RetireCount}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RV32I core, replacing the bare PC register at the head of the fetch path. Holds the architectural PC and selects the next PC from sequential, branch/jump, trap and trap-return sources. Adds stall, halt/resume and a post-reset boot delay, along with misaligned-target trapping and a retired-instruction counter. Feeds instruction memory address and the PC+4 write-back path.

## Interface
- DWIDTH, 32, PC/target width
- RESET_VECTOR, 32'h0000_0000, PC value held during and after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on any trap
- BOOT_DELAY, 2, cycles in BOOT after reset release before fetch is valid (0 allowed)
- CNT_WIDTH, 64, width of RetireCount

- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-high
- Stall  in  1  hold PC this cycle
- BranchTaken  in  1  redirect to BranchTarget
- BranchTarget  in  DWIDTH  branch/jump destination
- Trap  in  1  external trap request (ecall/illegal/etc.)
- MRet  in  1  return to Epc
- Halt  in  1  request halt
- Resume  in  1  leave HALTED
- PC  out  DWIDTH  current PC (registered)
- PCPlus4  out  DWIDTH  PC + 4 (combinational, wraps modulo 2^DWIDTH)
- Epc  out  DWIDTH  saved trap PC (registered)
- Valid  out  1  PC is a valid fetch address (high only in RUN)
- Misaligned  out  1  BranchTaken with BranchTarget[1:0] != 0 in RUN (combinational)
- RetireCount  out  CNT_WIDTH  count of instructions advanced past

## Operation
- States (shared enum): BOOT, RUN, HALTED.
- Reset (Rst high at edge): PC=RESET_VECTOR, Epc=0, RetireCount=0, boot counter=0, state=BOOT (RUN if BOOT_DELAY==0). Rst overrides everything, including mid-trap/halt.
- BOOT: Valid=0, PC held; counter increments each cycle; after BOOT_DELAY cycles -> RUN.
- RUN next-PC priority (highest first):
  - Trap or Misaligned: Epc<=PC, PC<=TRAP_VECTOR; no retire.
  - Stall: PC held; no retire; Halt, MRet, BranchTaken ignored.
  - MRet: PC<=Epc; retire.
  - BranchTaken (aligned): PC<=BranchTarget; retire.
  - otherwise: PC<=PCPlus4; retire.
- Halt in RUN with no Trap/Misaligned/Stall: the normal update for that cycle still applies, then state->HALTED. Halt together with Trap/Misaligned: trap taken, Halt ignored.
- HALTED: Valid=0, PC/Epc/RetireCount held, all inputs except Resume and Rst ignored; Resume -> RUN next cycle.
- RetireCount += 1 on each retiring RUN cycle; wraps from all-ones to 0.
- PCPlus4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- PC, Epc, state, RetireCount update on the rising edge; inputs sampled at that edge.
- Redirect latency: one cycle (target visible on PC the cycle after BranchTaken/Trap/MRet).
- Valid deasserts in the cycle state becomes HALTED; reasserts the cycle after Resume.
- Misaligned, PCPlus4, Valid are combinational from registered state and inputs.
- First valid fetch: cycle BOOT_DELAY+1 after Rst falls, with PC=RESET_VECTOR.

## Structure
- Package pc_seq_pkg: pc_state_t enum (BOOT, RUN, HALTED), PC_STEP = 4, ALIGN_MASK = 2'b11.
- One sub-module: wrap_counter (parametrised width, sync active-high clear, enable) for RetireCount; boot counter inline.

## Test plan
- Reset, BOOT_DELAY=2: Rst high 2 cycles, release -> Valid=0 for 2 cycles, then Valid=1, PC=0, next edge PC=4, RetireCount=1.
- BranchTaken with target 32'hA5A5_A5A4 -> PC=A5A5_A5A4 next cycle; target 32'h5A5A_5A5A -> Misaligned=1, PC=0000_0100, Epc=previous PC, RetireCount unchanged.
- Trap at PC=0x20 -> PC=0x100, Epc=0x20; MRet two cycles later -> PC=0x20.
- Stall 3 cycles with BranchTaken asserted -> PC and RetireCount unchanged; Trap during stall -> PC=0x100.
- Halt at PC=0x40 -> PC=0x44, Valid=0, held 5 cycles despite BranchTaken; Resume -> Valid=1, PC=0x48 following edge.
- PC at 32'hFFFF_FFFC, no events -> PC=0; RetireCount preset near max (CNT_WIDTH=4, 15) wraps to 0; Rst asserted in HALTED -> PC=0, state BOOT.
